// File: rtl/dmem_block_responder_pkg.sv
// Shared constants for the D-cache block responder: state encoding, default
// latencies and the block geometry of the data memory.
package dmem_block_responder_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE  = 8;
  localparam int DBLOCK_SIZE_BITS      = 128;
  localparam int DEFAULT_READ_LATENCY  = 4;
  localparam int DEFAULT_WRITE_LATENCY = 4;

  typedef enum logic [2:0] {
    DMEMR_IDLE    = 3'd0,
    DMEMR_RD_WAIT = 3'd1,
    DMEMR_WR_WAIT = 3'd2,
    DMEMR_RD_RESP = 3'd3,
    DMEMR_WR_RESP = 3'd4
  } dmemr_state_e;

  function automatic int maxLatency(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dmem_block_responder_counter.sv
// Latency countdown: loads a start value, decrements towards zero and holds
// there, flagging when it has run out.
module dmem_block_responder_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadValue_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dmem_block_responder.sv
// Memory-side responder for the D-cache miss path: holds the block array and
// serves refills and write-backs with fixed latencies and one-cycle done pulses.
module dmem_block_responder
  import dmem_block_responder_pkg::*;
#(
  parameter int ADDR_W        = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_BITS    = DBLOCK_SIZE_BITS,
  parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
  parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRen,
  input  logic                  memWen,
  input  logic [ADDR_W-1:0]     BlockAddr,
  input  logic [BLOCK_BITS-1:0] memDin,
  output logic [BLOCK_BITS-1:0] memDout,
  output logic                  memReadReady,
  output logic                  memWriteDone,
  output logic                  busy
);

  localparam int CNT_W = $clog2(maxLatency(READ_LATENCY, WRITE_LATENCY)) + 1;
  // The wait state itself accounts for one cycle, so load latency-1.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  dmemr_state_e          state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BLOCK_BITS-1:0] data_q;
  logic [BLOCK_BITS-1:0] memDout_q;
  logic                  memReadReady_q;
  logic                  memWriteDone_q;
  logic                  busy_q;

  logic [BLOCK_BITS-1:0] mem [0:2**ADDR_W-1];

  logic             cntLoad;
  logic             cntDec;
  logic             cntZero;
  logic [CNT_W-1:0] cntLoadValue;
  logic             memWe;

  always_comb begin
    cntLoad      = (state_q == DMEMR_IDLE) && (memWen || memRen);
    cntLoadValue = memWen ? WR_LOAD : RD_LOAD;
    cntDec       = (state_q == DMEMR_RD_WAIT) || (state_q == DMEMR_WR_WAIT);
    memWe        = (state_q == DMEMR_WR_WAIT) && cntZero;
  end

  dmem_block_responder_counter #(
    .WIDTH(CNT_W)
  ) uCounter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cntLoad),
    .loadValue_i(cntLoadValue),
    .dec_i      (cntDec),
    .zero_o     (cntZero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= DMEMR_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      memDout_q      <= '0;
      memReadReady_q <= 1'b0;
      memWriteDone_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      memReadReady_q <= 1'b0;
      memWriteDone_q <= 1'b0;
      case (state_q)
        DMEMR_IDLE: begin
          // A simultaneous read stays pending and is picked up on a later IDLE cycle.
          if (memWen) begin
            addr_q  <= BlockAddr;
            data_q  <= memDin;
            state_q <= DMEMR_WR_WAIT;
            busy_q  <= 1'b1;
          end else if (memRen) begin
            addr_q  <= BlockAddr;
            state_q <= DMEMR_RD_WAIT;
            busy_q  <= 1'b1;
          end
        end
        DMEMR_RD_WAIT: begin
          if (cntZero) begin
            memDout_q      <= mem[addr_q];
            memReadReady_q <= 1'b1;
            state_q        <= DMEMR_RD_RESP;
          end
        end
        DMEMR_WR_WAIT: begin
          if (cntZero) begin
            memWriteDone_q <= 1'b1;
            state_q        <= DMEMR_WR_RESP;
          end
        end
        DMEMR_RD_RESP, DMEMR_WR_RESP: begin
          state_q <= DMEMR_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= DMEMR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array is never cleared; an aborted write cannot commit because reset forces IDLE.
  always_ff @(posedge clock) begin
    if (memWe) begin
      mem[addr_q] <= data_q;
    end
  end

  assign memDout      = memDout_q;
  assign memReadReady = memReadReady_q;
  assign memWriteDone = memWriteDone_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: a latency-4 instance and a
// latency-1 instance, directed refill/write-back sequences.
module tb_dmem_block_responder;

  localparam int AW = 8;
  localparam int BW = 128;

  localparam logic [BW-1:0] D05  = 128'h0505_0505_1111_2222_3333_4444_5555_0505;
  localparam logic [BW-1:0] D12A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [BW-1:0] D12B = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
  localparam logic [BW-1:0] D44  = 128'h4444_0000_4444_0000_4444_0000_4444_0044;
  localparam logic [BW-1:0] D30  = 128'h3030_3030_ABCD_EF01_2345_6789_3030_3030;
  localparam logic [BW-1:0] D50  = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_F0F0_0050_0050;
  localparam logic [BW-1:0] D60  = 128'h6060_6060_6060_6060_6060_6060_6060_6060;
  localparam logic [BW-1:0] D6X  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [BW-1:0] D07  = 128'h0707_0707_1234_5678_9ABC_DEF0_0707_0707;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          memRen, memWen;
  logic [AW-1:0] BlockAddr;
  logic [BW-1:0] memDin, memDout;
  logic          memReadReady, memWriteDone, busy;

  logic          memRen1, memWen1;
  logic [AW-1:0] BlockAddr1;
  logic [BW-1:0] memDin1, memDout1;
  logic          memReadReady1, memWriteDone1, busy1;

  dmem_block_responder #(
    .ADDR_W(AW), .BLOCK_BITS(BW), .READ_LATENCY(4), .WRITE_LATENCY(4)
  ) dut (
    .clock(clock), .reset(reset), .memRen(memRen), .memWen(memWen),
    .BlockAddr(BlockAddr), .memDin(memDin), .memDout(memDout),
    .memReadReady(memReadReady), .memWriteDone(memWriteDone), .busy(busy)
  );

  dmem_block_responder #(
    .ADDR_W(AW), .BLOCK_BITS(BW), .READ_LATENCY(1), .WRITE_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset(reset), .memRen(memRen1), .memWen(memWen1),
    .BlockAddr(BlockAddr1), .memDin(memDin1), .memDout(memDout1),
    .memReadReady(memReadReady1), .memWriteDone(memWriteDone1), .busy(busy1)
  );

  int cycleCnt = 0;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            isWrite;
    logic [BW-1:0] data;
    int            cycle;
  } exp_t;

  exp_t expQ0[$];
  exp_t expQ1[$];

  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Pop the oldest expectation whenever an instance pulses and check kind, timing and data.
  always @(negedge clock) begin
    exp_t e;
    if (memReadReady || memWriteDone) begin
      if (expQ0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut unexpectedPulse actual=rd%0b/wr%0b expected=none at cycle %0d",
                 memReadReady, memWriteDone, cycleCnt);
      end else begin
        e = expQ0.pop_front();
        checkOutput("dut pulseKind", BW'({memReadReady, memWriteDone}), BW'({!e.isWrite, e.isWrite}));
        checkOutput("dut pulseCycle", BW'(cycleCnt), BW'(e.cycle));
        if (!e.isWrite) checkOutput("dut readData", memDout, e.data);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (memReadReady1 || memWriteDone1) begin
      if (expQ1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut1 unexpectedPulse actual=rd%0b/wr%0b expected=none at cycle %0d",
                 memReadReady1, memWriteDone1, cycleCnt);
      end else begin
        e = expQ1.pop_front();
        checkOutput("dut1 pulseKind", BW'({memReadReady1, memWriteDone1}), BW'({!e.isWrite, e.isWrite}));
        checkOutput("dut1 pulseCycle", BW'(cycleCnt), BW'(e.cycle));
        if (!e.isWrite) checkOutput("dut1 readData", memDout1, e.data);
      end
    end
  end

  function automatic bit pulseOf(input int inst, input bit wr);
    if (inst == 0) return wr ? memWriteDone : memReadReady;
    return wr ? memWriteDone1 : memReadReady1;
  endfunction

  task automatic waitPulse(input int inst, input bit wr);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (pulseOf(inst, wr)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL inst%0d pulseTimeout actual=none expected=%s pulse", inst, wr ? "write" : "read");
    end
  endtask

  // Issue one request to an idle instance, expect its pulse latency cycles after accept.
  task automatic applyStimulus(input int inst, input bit wr, input logic [AW-1:0] addr,
                               input logic [BW-1:0] din, input logic [BW-1:0] expData);
    exp_t e;
    int lat = (inst == 0) ? 4 : 1;
    @(negedge clock);
    if (inst == 0) begin
      memWen = wr; memRen = !wr; BlockAddr = addr; memDin = din;
    end else begin
      memWen1 = wr; memRen1 = !wr; BlockAddr1 = addr; memDin1 = din;
    end
    e.isWrite = wr;
    e.data    = expData;
    e.cycle   = cycleCnt + 1 + lat;
    if (inst == 0) expQ0.push_back(e);
    else           expQ1.push_back(e);
    waitPulse(inst, wr);
    if (inst == 0) begin
      memWen = 1'b0; memRen = 1'b0;
    end else begin
      memWen1 = 1'b0; memRen1 = 1'b0;
    end
  endtask

  // Start a request on the latency-4 instance and pull reset while it waits.
  task automatic applyAbort(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] din);
    @(negedge clock);
    memWen = wr; memRen = !wr; BlockAddr = addr; memDin = din;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    memWen = 1'b0;
    memRen = 1'b0;
    @(negedge clock);
    checkOutput("abort memDout", memDout, '0);
    checkOutput("abort memReadReady", BW'(memReadReady), '0);
    checkOutput("abort memWriteDone", BW'(memWriteDone), '0);
    checkOutput("abort busy", BW'(busy), '0);
    reset = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    exp_t e;
    reset = 1'b0;
    memRen = 1'b0; memWen = 1'b0; BlockAddr = '0; memDin = '0;
    memRen1 = 1'b0; memWen1 = 1'b0; BlockAddr1 = '0; memDin1 = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset memDout", memDout, '0);
    checkOutput("reset memReadReady", BW'(memReadReady), '0);
    checkOutput("reset memWriteDone", BW'(memWriteDone), '0);
    checkOutput("reset busy", BW'(busy), '0);
    reset = 1'b1;

    $display("[TB] preload blocks");
    applyStimulus(0, 1'b1, 8'h05, D05, '0);
    applyStimulus(0, 1'b1, 8'h12, D12A, '0);
    applyStimulus(0, 1'b1, 8'h44, D44, '0);
    applyStimulus(0, 1'b1, 8'h60, D60, '0);

    $display("[TB] basic refill");
    applyStimulus(0, 1'b0, 8'h12, '0, D12A);

    $display("[TB] reset mid read and mid write");
    applyStimulus(0, 1'b0, 8'h44, '0, D44);
    applyAbort(1'b0, 8'h05, '0);
    applyStimulus(0, 1'b0, 8'h05, '0, D05);
    applyAbort(1'b1, 8'h60, D6X);
    applyStimulus(0, 1'b0, 8'h60, '0, D60);

    $display("[TB] write-back then read back");
    applyStimulus(0, 1'b1, 8'h12, D12B, '0);
    applyStimulus(0, 1'b0, 8'h12, '0, D12B);

    $display("[TB] miss: write-back followed immediately by refill");
    applyStimulus(0, 1'b1, 8'h30, D30, '0);
    applyStimulus(0, 1'b0, 8'h44, '0, D44);
    applyStimulus(0, 1'b0, 8'h30, '0, D30);

    $display("[TB] simultaneous read and write");
    @(negedge clock);
    memWen = 1'b1; memRen = 1'b1; BlockAddr = 8'h50; memDin = D50;
    base = cycleCnt;
    e.isWrite = 1'b1; e.data = '0;  e.cycle = base + 5;  expQ0.push_back(e);
    e.isWrite = 1'b0; e.data = D50; e.cycle = base + 11; expQ0.push_back(e);
    waitPulse(0, 1'b1);
    memWen = 1'b0;
    waitPulse(0, 1'b0);
    memRen = 1'b0;

    $display("[TB] inputs changed during read wait");
    @(negedge clock);
    memRen = 1'b1; BlockAddr = 8'h12;
    base = cycleCnt;
    e.isWrite = 1'b0; e.data = D12B; e.cycle = base + 5; expQ0.push_back(e);
    @(negedge clock);
    memRen = 1'b0; BlockAddr = 8'h44;
    waitPulse(0, 1'b0);

    $display("[TB] latency-1 instance");
    applyStimulus(1, 1'b1, 8'h07, D07, '0);
    applyStimulus(1, 1'b0, 8'h07, '0, D07);
    applyStimulus(1, 1'b1, 8'h07, D12B, '0);
    applyStimulus(1, 1'b0, 8'h07, '0, D12B);

    repeat (6) @(negedge clock);
    checkOutput("dut queueEmpty", BW'(expQ0.size()), '0);
    checkOutput("dut1 queueEmpty", BW'(expQ1.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
